// File: rtl/sram_responder_if.sv
// Address, control and byte-lane pins of the external 16-bit asynchronous SRAM.
// The bidirectional data bus stays a plain inout port on the responder.
interface sram_responder_if;
  logic [17:0] SRAM_A;
  logic        SRAM_CE_n;
  logic        SRAM_OE_n;
  logic        SRAM_WE_n;
  logic        SRAM_LB_n;
  logic        SRAM_UB_n;

  modport master (
    output SRAM_A, SRAM_CE_n, SRAM_OE_n, SRAM_WE_n, SRAM_LB_n, SRAM_UB_n
  );

  modport slave (
    input SRAM_A, SRAM_CE_n, SRAM_OE_n, SRAM_WE_n, SRAM_LB_n, SRAM_UB_n
  );
endinterface

// File: rtl/sram_responder.sv
// Clocked SRAM pin-level responder: commits writes at the end of each WE pulse
// and returns read data with a fixed two-edge latency on the tristate bus.
module sram_responder #(
  parameter int unsigned MEM_WORDS = 262144
) (
  input  logic              i_clock,
  input  logic              i_reset,
  sram_responder_if.slave   bus,
  inout  wire        [15:0] SRAM_D,
  output logic       [31:0] o_write_count,
  output logic              o_error
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic [15:0]   mem [MEM_WORDS];

  logic [AW-1:0] a_q;
  logic [15:0]   rdata_q;
  logic          wr_act;
  logic          wr_act_q;
  logic          commit;
  logic          contention;

  logic [AW-1:0] wa;
  logic [15:0]   wd;
  logic          wlb;
  logic          wub;
  logic [15:0]   wmerged;

  logic          rd_drive;
  logic          drive_lo;
  logic          drive_hi;

  always_comb begin
    wr_act     = !bus.SRAM_CE_n && !bus.SRAM_WE_n;
    contention = !bus.SRAM_CE_n && !bus.SRAM_OE_n && !bus.SRAM_WE_n;
    commit     = wr_act_q && !wr_act;
  end

  // Value the committed word will hold, used to forward into the read pipe.
  always_comb begin
    wmerged       = mem[wa];
    if (!wlb) wmerged[7:0]  = wd[7:0];
    if (!wub) wmerged[15:8] = wd[15:8];
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset && commit) begin
      if (!wlb) mem[wa][7:0]  <= wd[7:0];
      if (!wub) mem[wa][15:8] <= wd[15:8];
    end
  end

  // Long WE pulses re-latch every edge; the last sample is what commits.
  always_ff @(posedge i_clock) begin
    if (wr_act) begin
      wa  <= bus.SRAM_A[AW-1:0];
      wd  <= SRAM_D;
      wlb <= bus.SRAM_LB_n;
      wub <= bus.SRAM_UB_n;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      a_q           <= '0;
      rdata_q       <= '0;
      wr_act_q      <= 1'b0;
      o_write_count <= '0;
      o_error       <= 1'b0;
    end else begin
      a_q      <= bus.SRAM_A[AW-1:0];
      wr_act_q <= wr_act;
      if (commit && (wa == a_q)) begin
        rdata_q <= wmerged;
      end else begin
        rdata_q <= mem[a_q];
      end
      if (commit) begin
        o_write_count <= o_write_count + 32'd1;
      end
      if (contention) begin
        o_error <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_drive = !i_reset && !bus.SRAM_CE_n && !bus.SRAM_OE_n && bus.SRAM_WE_n;
    drive_lo = rd_drive && !bus.SRAM_LB_n;
    drive_hi = rd_drive && !bus.SRAM_UB_n;
  end

  assign SRAM_D[7:0]  = drive_lo ? rdata_q[7:0]  : 8'hzz;
  assign SRAM_D[15:8] = drive_hi ? rdata_q[15:8] : 8'hzz;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder; a weak pull-up makes undriven bus bits read as 1,
// so floating lanes are checked against 0xFF while the driven data avoids that value.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] tb_d;
  logic        tb_d_oe;
  wire  [15:0] SRAM_D;
  logic [31:0] wcount;
  logic        err;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_count;
  logic [15:0] model [int unsigned];
  logic [15:0] sb_q [$];
  logic [15:0] obs_lo;
  logic [15:0] obs_hi;

  sram_responder_if bus_if ();

  assign SRAM_D = tb_d_oe ? tb_d : 16'hzzzz;
  pullup (SRAM_D);

  sram_responder #(.MEM_WORDS(262144)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .bus           (bus_if.slave),
    .SRAM_D        (SRAM_D),
    .o_write_count (wcount),
    .o_error       (err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic idle;
    bus_if.SRAM_CE_n = 1'b1;
    bus_if.SRAM_OE_n = 1'b1;
    bus_if.SRAM_WE_n = 1'b1;
    bus_if.SRAM_LB_n = 1'b0;
    bus_if.SRAM_UB_n = 1'b0;
    tb_d_oe          = 1'b0;
  endtask

  function automatic logic [15:0] model_rd(input int unsigned addr);
    return model.exists(addr) ? model[addr] : 16'h0000;
  endfunction

  task automatic write_word(input int unsigned addr, input logic [15:0] data,
                            input logic lb_n, input logic ub_n);
    logic [15:0] m;
    bus_if.SRAM_A    = addr[17:0];
    tb_d             = data;
    tb_d_oe          = 1'b1;
    bus_if.SRAM_CE_n = 1'b0;
    bus_if.SRAM_OE_n = 1'b1;
    bus_if.SRAM_WE_n = 1'b0;
    bus_if.SRAM_LB_n = lb_n;
    bus_if.SRAM_UB_n = ub_n;
    tick();
    idle();
    tick();
    m = model_rd(addr);
    if (!lb_n) m[7:0]  = data[7:0];
    if (!ub_n) m[15:8] = data[15:8];
    model[addr] = m;
    exp_count++;
    check("write_count", wcount, exp_count);
  endtask

  task automatic read_word(input int unsigned addr, input logic lb_n, input logic ub_n,
                           input string tag, output logic [15:0] obs);
    logic [15:0] m;
    m = model_rd(addr);
    bus_if.SRAM_A    = addr[17:0];
    bus_if.SRAM_CE_n = 1'b0;
    bus_if.SRAM_OE_n = 1'b0;
    bus_if.SRAM_WE_n = 1'b1;
    bus_if.SRAM_LB_n = lb_n;
    bus_if.SRAM_UB_n = ub_n;
    tb_d_oe          = 1'b0;
    sb_q.push_back({ub_n ? 8'hFF : m[15:8], lb_n ? 8'hFF : m[7:0]});
    tick();
    tick();
    obs = SRAM_D;
    check(tag, obs, sb_q.pop_front());
    idle();
  endtask

  initial begin
    exp_count      = 32'd0;
    tb_d           = 16'h0000;
    bus_if.SRAM_A  = '0;
    idle();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_count", wcount, 32'd0);
    check("rst_error", {31'd0, err}, 32'd0);
    bus_if.SRAM_CE_n = 1'b0;
    bus_if.SRAM_OE_n = 1'b0;
    #1;
    check("rst_rdata", SRAM_D, 16'h0000);
    idle();
    #1;
    check("idle_z", SRAM_D, 16'hFFFF);

    // Single write / read
    write_word(32'h10, 16'h1234, 1'b0, 1'b0);
    read_word(32'h10, 1'b0, 1'b0, "single_rd", obs_lo);

    // Byte lanes
    write_word(32'h20, 16'hAAAA, 1'b0, 1'b0);
    write_word(32'h20, 16'h5566, 1'b1, 1'b0);
    read_word(32'h20, 1'b0, 1'b0, "ub_only_rd", obs_lo);
    check("ub_merge_const", obs_lo, 16'h55AA);
    read_word(32'h20, 1'b1, 1'b0, "lb_off_rd", obs_lo);

    // Controller-style 32-bit write to byte address 0x40
    write_word(32'h20, 16'hBEEF, 1'b0, 1'b0);
    write_word(32'h21, 16'hDEAD, 1'b0, 1'b0);
    tick();
    read_word(32'h20, 1'b0, 1'b0, "w32_lo", obs_lo);
    read_word(32'h21, 1'b0, 1'b0, "w32_hi", obs_hi);
    check("w32_word", {obs_hi, obs_lo}, 32'hDEADBEEF);

    // Write-first forwarding and two-edge latency
    write_word(32'h5, 16'h1111, 1'b0, 1'b0);
    write_word(32'h6, 16'h6666, 1'b0, 1'b0);
    bus_if.SRAM_A    = 18'h5;
    tb_d             = 16'h7777;
    tb_d_oe          = 1'b1;
    bus_if.SRAM_CE_n = 1'b0;
    bus_if.SRAM_WE_n = 1'b0;
    tick();
    bus_if.SRAM_WE_n = 1'b1;
    bus_if.SRAM_OE_n = 1'b0;
    tb_d_oe          = 1'b0;
    model[5]         = 16'h7777;
    exp_count++;
    sb_q.push_back(16'h7777);
    tick();
    check("write_first", SRAM_D, sb_q.pop_front());
    check("wf_count", wcount, exp_count);
    bus_if.SRAM_A = 18'h6;
    sb_q.push_back(model_rd(5));
    tick();
    check("lat_hold", SRAM_D, sb_q.pop_front());
    sb_q.push_back(model_rd(6));
    tick();
    check("lat_switch", SRAM_D, sb_q.pop_front());
    idle();

    // Contention with both lanes off: error sets, bus floats, commit still counted
    bus_if.SRAM_A    = 18'h40;
    bus_if.SRAM_LB_n = 1'b1;
    bus_if.SRAM_UB_n = 1'b1;
    bus_if.SRAM_CE_n = 1'b0;
    bus_if.SRAM_OE_n = 1'b0;
    bus_if.SRAM_WE_n = 1'b0;
    #1;
    check("cont_bus_z", SRAM_D, 16'hFFFF);
    tick();
    check("cont_error", {31'd0, err}, 32'd1);
    check("cont_bus_z2", SRAM_D, 16'hFFFF);
    idle();
    tick();
    exp_count++;
    check("cont_count", wcount, exp_count);
    repeat (3) tick();
    check("err_sticky", {31'd0, err}, 32'd1);

    // Reset in the middle of a WE pulse
    write_word(32'h30, 16'h3030, 1'b0, 1'b0);
    bus_if.SRAM_A    = 18'h30;
    tb_d             = 16'hBBBB;
    tb_d_oe          = 1'b1;
    bus_if.SRAM_CE_n = 1'b0;
    bus_if.SRAM_WE_n = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    idle();
    rst = 1'b0;
    exp_count = 32'd0;
    tick();
    tick();
    check("rst_mid_count", wcount, exp_count);
    check("rst_mid_error", {31'd0, err}, 32'd0);
    read_word(32'h30, 1'b0, 1'b0, "rst_mid_word", obs_lo);
    read_word(32'h10, 1'b0, 1'b0, "mem_kept", obs_lo);
    check("rd_no_count", wcount, exp_count);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
# sram_responder

Clocked responder for the external 16-bit asynchronous SRAM pin interface, used as the far end of the SRAM controller. It accepts the SRAM address, control and byte-lane pins, stores writes into an internal word array, and drives read data back onto the bidirectional data bus with a fixed two-edge latency. It serves as the memory model in simulation benches and as an FPGA loopback target for controller bring-up.

## Interface
- MEM_WORDS, 262144: depth of the internal 16-bit array; the address is taken modulo MEM_WORDS using its low log2(MEM_WORDS) bits; must be a power of two.
- i_clock  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  reset, synchronous, active-high.
- SRAM_A  in  18  word address.
- SRAM_D  inout  16  data bus; driven only during reads, otherwise high-Z.
- SRAM_CE_n  in  1  chip enable, active low.
- SRAM_OE_n  in  1  output enable, active low.
- SRAM_WE_n  in  1  write enable, active low.
- SRAM_LB_n  in  1  lower byte lane enable (D[7:0]), active low.
- SRAM_UB_n  in  1  upper byte lane enable (D[15:8]), active low.
- o_write_count  out  32  number of committed writes; wraps 0xFFFFFFFF -> 0.
- o_error  out  1  sticky contention flag.

## Operation
- Per-edge sampling: wr_act = !CE_n && !WE_n; a_q <= SRAM_A.
- Write capture: every edge with wr_act=1 latches A, D, LB_n and UB_n into wa/wd/wlb/wub; wr_act_q <= wr_act.
- Write commit: on the edge where wr_act_q=1 and wr_act=0, the array is written at wa. D[7:0] is written only if wlb=0, and D[15:8] only if wub=0. o_write_count increments by 1 even if both lanes are disabled.
- A long WE pulse re-latches each cycle; exactly one commit occurs per pulse, using the last-latched values.
- Read pipeline: rdata_q <= mem[a_q] every edge, regardless of the control pins.
- Write-first: if a commit and the read of rdata_q target the same word on the same edge, rdata_q receives the merged new value.
- Bus drive is combinational on the live pins: drive when !CE_n && !OE_n && WE_n.
  - D[7:0] = rdata_q[7:0] if !LB_n, else Z.
  - D[15:8] = rdata_q[15:8] if !UB_n, else Z.
  - All bits are Z otherwise, including during reset.
- Contention: any edge sampling !CE_n && !OE_n && !WE_n sets o_error; only reset clears it.
- Memory contents are not cleared by reset.

## Timing
- Reset values: a_q=0, rdata_q=0, wr_act_q=0 (prevents a spurious commit after reset), o_write_count=0, o_error=0. Latched write fields are don't-care.
- Reset during an active WE pulse discards the pending write; no commit occurs on release even if WE_n rises afterwards.
- Read latency:
  - Address stable before edge N -> a_q at edge N -> valid on the bus after edge N+1.
  - The controller's sample at edge N+2 (count==2 relative to request start) sees correct data.
  - Each address change restarts this two-edge latency.
- Write latency: a WE low phase sampled at edge N commits at the first edge M>N with wr_act=0. Read-back of that word can be valid after edge M+1.
- Address change with WE still low: data is captured per edge, so the last-sampled address wins. The controller raises WE before changing address.
- Back-to-back 32-bit controller write: two commits (low word at even address, high word at even+1), o_write_count +2.

## Test plan
- Single write/read: WE low 1 cycle at A=0x00010, D=0x1234, both lanes -> commit next edge, count=1; then OE low at A=0x00010 -> D=0x1234 after two edges.
- Byte lanes: preload 0xAAAA at 0x00020; write 0x5566 with UB only -> read 0x55AA; read with LB_n=1 -> D[7:0]=Z, D[15:8]=0x55.
- Controller-style 32-bit: write 0xDEADBEEF at byte address 0x40 (words 0x20/0x21, 6-cycle sequence) -> word 0x20=0xBEEF, word 0x21=0xDEAD, count +2; 32-bit read returns 0xDEADBEEF.
- Latency/write-first: commit 0x7777 to word 5 on the same edge a_q=5 -> rdata_q=0x7777 next; address switch 5->6 -> bus shows mem[6] exactly two edges later.
- Contention: CE_n=OE_n=WE_n=0 for 1 cycle -> o_error=1 and stays 1 until reset; bus Z throughout.
- Reset mid-write: WE low at 0x30 with data 0xBBBB, reset asserted before WE rises -> no commit, word 0x30 unchanged, count=0, o_error=0; earlier memory contents preserved.
